multicycle_control: RTL and testbench

Multi-cycle MIPS control unit: a Moore state machine that sequences each instruction over 3–5 cycles and drives the shared-ALU/shared-memory datapath (IR, PC, register file, unified memory). It supports R-type, addi, beq, j, lw and sw. It adds an optional memory-ready handshake and a sticky illegal-opcode trap. Sits beside the datapath in place of the single-cycle controller; opcode comes from the instruction register.

---
 rtl/mc_ctrl_pkg.sv | 71 +++++++
 rtl/multicycle_control_outdec.sv | 67 ++++++
 rtl/multicycle_control.sv | 93 +++++++++
 tb/tb_multicycle_control.sv | 354 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mc_ctrl_pkg.sv
// Shared definitions for the multi-cycle MIPS control unit:
// opcodes, state encodings, datapath select codes, control bundle.
package mc_ctrl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_MEM_ADDR  = 4'd2,
        S_MEM_RD    = 4'd3,
        S_MEM_WB    = 4'd4,
        S_MEM_WR    = 4'd5,
        S_R_EXEC    = 4'd6,
        S_R_WB      = 4'd7,
        S_BEQ       = 4'd8,
        S_JMP       = 4'd9,
        S_ADDI_EXEC = 4'd10,
        S_ADDI_WB   = 4'd11,
        S_TRAP      = 4'd12
    } state_t;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_REG  = 2'b00;
    localparam logic [1:0] SRCB_FOUR = 2'b01;
    localparam logic [1:0] SRCB_IMM  = 2'b10;
    localparam logic [1:0] SRCB_BOFF = 2'b11;

    localparam logic [1:0] PC_ALU    = 2'b00;
    localparam logic [1:0] PC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_JUMP   = 2'b10;

    typedef struct packed {
        logic [1:0] alu_op;
        logic       reg_dst;
        logic       mem_2_reg;
        logic       reg_write;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       pc_write;
        logic       pc_write_cond;
        logic       i_or_d;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] pc_source;
    } ctrl_t;

    function automatic state_t dispatch(input logic [5:0] op);
        state_t s;
        s = S_TRAP;
        unique case (1'b1)
            (op == OP_RTYPE):               s = S_R_EXEC;
            (op == OP_ADDI):                s = S_ADDI_EXEC;
            (op == OP_BEQ):                 s = S_BEQ;
            (op == OP_J):                   s = S_JMP;
            (op == OP_LW) || (op == OP_SW): s = S_MEM_ADDR;
            default:                        s = S_TRAP;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/multicycle_control_outdec.sv
// Moore output decoder: state (plus memory ready) to control vector.
module multicycle_control_outdec
    import mc_ctrl_pkg::*;
(
    input  state_t state,
    input  logic   mem_ready,
    output ctrl_t  ctrl
);

    always_comb begin
        ctrl           = '0;
        ctrl.alu_op    = ALU_ADD;
        ctrl.alu_src_b = SRCB_REG;
        ctrl.pc_source = PC_ALU;
        case (state)
            S_FETCH: begin
                // IR and PC only advance once the fetch completes
                ctrl.mem_read  = 1'b1;
                ctrl.alu_src_b = SRCB_FOUR;
                ctrl.ir_write  = mem_ready;
                ctrl.pc_write  = mem_ready;
            end
            S_DECODE: begin
                ctrl.alu_src_b = SRCB_BOFF;
            end
            S_MEM_ADDR, S_ADDI_EXEC: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
            end
            S_MEM_RD: begin
                ctrl.mem_read = 1'b1;
                ctrl.i_or_d   = 1'b1;
            end
            S_MEM_WB: begin
                ctrl.mem_2_reg = 1'b1;
                ctrl.reg_write = 1'b1;
            end
            S_MEM_WR: begin
                ctrl.mem_write = 1'b1;
                ctrl.i_or_d    = 1'b1;
            end
            S_R_EXEC: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_op    = ALU_FUNCT;
            end
            S_R_WB: begin
                ctrl.reg_dst   = 1'b1;
                ctrl.reg_write = 1'b1;
            end
            S_BEQ: begin
                ctrl.alu_src_a     = 1'b1;
                ctrl.alu_op        = ALU_SUB;
                ctrl.pc_write_cond = 1'b1;
                ctrl.pc_source     = PC_ALUOUT;
            end
            S_JMP: begin
                ctrl.pc_write  = 1'b1;
                ctrl.pc_source = PC_JUMP;
            end
            S_ADDI_WB: begin
                ctrl.reg_write = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle MIPS control FSM: state register, sequencing,
// sticky illegal-opcode flag and reset gating of write enables.
module multicycle_control
    import mc_ctrl_pkg::*;
#(
    parameter bit MEM_HANDSHAKE = 1'b1,
    parameter int STATE_W       = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [5:0]         opcode,
    input  logic               mem_ready,
    output logic [1:0]         alu_op,
    output logic               reg_dst,
    output logic               mem_2_reg,
    output logic               reg_write,
    output logic               mem_read,
    output logic               mem_write,
    output logic               ir_write,
    output logic               pc_write,
    output logic               pc_write_cond,
    output logic               i_or_d,
    output logic               alu_src_a,
    output logic [1:0]         alu_src_b,
    output logic [1:0]         pc_source,
    output logic               illegal_op,
    output logic [STATE_W-1:0] state
);

    state_t state_q;
    state_t state_d;
    state_t state_eff;
    logic   rdy;
    logic   illegal_q;
    ctrl_t  dec;

    assign rdy = MEM_HANDSHAKE ? mem_ready : 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_FETCH;
            illegal_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_d == S_TRAP) begin
                illegal_q <= 1'b1;
            end
        end
    end

    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH:     state_d = rdy ? S_DECODE : S_FETCH;
            S_DECODE:    state_d = dispatch(opcode);
            S_MEM_ADDR:  state_d = (opcode == OP_SW) ? S_MEM_WR
                                                     : S_MEM_RD;
            S_MEM_RD:    state_d = rdy ? S_MEM_WB : S_MEM_RD;
            S_MEM_WR:    state_d = rdy ? S_FETCH : S_MEM_WR;
            S_R_EXEC:    state_d = S_R_WB;
            S_ADDI_EXEC: state_d = S_ADDI_WB;
            S_TRAP:      state_d = S_TRAP;
            default:     state_d = S_FETCH;
        endcase
    end

    // during reset the outputs look like FETCH with all writes held off
    assign state_eff = rst ? S_FETCH : state_q;

    multicycle_control_outdec u_outdec (
        .state     (state_eff),
        .mem_ready (rdy),
        .ctrl      (dec)
    );

    assign alu_op        = dec.alu_op;
    assign reg_dst       = dec.reg_dst;
    assign mem_2_reg     = dec.mem_2_reg;
    assign mem_read      = dec.mem_read;
    assign i_or_d        = dec.i_or_d;
    assign alu_src_a     = dec.alu_src_a;
    assign alu_src_b     = dec.alu_src_b;
    assign pc_source     = dec.pc_source;
    assign reg_write     = dec.reg_write & ~rst;
    assign mem_write     = dec.mem_write & ~rst;
    assign ir_write      = dec.ir_write & ~rst;
    assign pc_write      = dec.pc_write & ~rst;
    assign pc_write_cond = dec.pc_write_cond & ~rst;

    assign illegal_op = illegal_q;
    assign state      = STATE_W'(state_eff);

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: per-cycle state and
// control-vector checks against hand-derived expectations.
module tb_multicycle_control;

    // {alu_op, reg_dst, mem_2_reg, reg_write, mem_read, mem_write,
    //  ir_write, pc_write, pc_write_cond, i_or_d, alu_src_a,
    //  alu_src_b, pc_source}
    localparam logic [15:0] V_FETCH   = 16'b00_0_0_0_1_0_1_1_0_0_0_01_00;
    localparam logic [15:0] V_FETCH_S = 16'b00_0_0_0_1_0_0_0_0_0_0_01_00;
    localparam logic [15:0] V_RST     = V_FETCH_S;
    localparam logic [15:0] V_DEC     = 16'b00_0_0_0_0_0_0_0_0_0_0_11_00;
    localparam logic [15:0] V_MADDR   = 16'b00_0_0_0_0_0_0_0_0_0_1_10_00;
    localparam logic [15:0] V_MEMRD   = 16'b00_0_0_0_1_0_0_0_0_1_0_00_00;
    localparam logic [15:0] V_MEMWB   = 16'b00_0_1_1_0_0_0_0_0_0_0_00_00;
    localparam logic [15:0] V_MEMWR   = 16'b00_0_0_0_0_1_0_0_0_1_0_00_00;
    localparam logic [15:0] V_REXEC   = 16'b10_0_0_0_0_0_0_0_0_0_1_00_00;
    localparam logic [15:0] V_RWB     = 16'b00_1_0_1_0_0_0_0_0_0_0_00_00;
    localparam logic [15:0] V_BEQ     = 16'b01_0_0_0_0_0_0_0_1_0_1_00_01;
    localparam logic [15:0] V_JMP     = 16'b00_0_0_0_0_0_0_1_0_0_0_00_10;
    localparam logic [15:0] V_AWB     = 16'b00_0_0_1_0_0_0_0_0_0_0_00_00;
    localparam logic [15:0] V_TRAP    = 16'b0;

    logic       clk;
    logic       rst;
    logic [5:0] opcode;
    logic       mem_ready;
    logic [1:0] alu_op;
    logic       reg_dst;
    logic       mem_2_reg;
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       pc_write;
    logic       pc_write_cond;
    logic       i_or_d;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] pc_source;
    logic       illegal_op;
    logic [3:0] state;
    logic [15:0] vec;

    logic       rst_nh;
    logic [5:0] op_nh;
    logic [1:0] alu_op_nh;
    logic       reg_dst_nh;
    logic       mem_2_reg_nh;
    logic       reg_write_nh;
    logic       mem_read_nh;
    logic       mem_write_nh;
    logic       ir_write_nh;
    logic       pc_write_nh;
    logic       pc_write_cond_nh;
    logic       i_or_d_nh;
    logic       alu_src_a_nh;
    logic [1:0] alu_src_b_nh;
    logic [1:0] pc_source_nh;
    logic       illegal_op_nh;
    logic [3:0] state_nh;
    logic [15:0] vec_nh;

    int vectors;
    int errors;

    multicycle_control #(.MEM_HANDSHAKE(1'b1), .STATE_W(4)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready),
        .alu_op(alu_op), .reg_dst(reg_dst), .mem_2_reg(mem_2_reg),
        .reg_write(reg_write), .mem_read(mem_read),
        .mem_write(mem_write), .ir_write(ir_write),
        .pc_write(pc_write), .pc_write_cond(pc_write_cond),
        .i_or_d(i_or_d), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .pc_source(pc_source),
        .illegal_op(illegal_op), .state(state)
    );

    multicycle_control #(.MEM_HANDSHAKE(1'b0), .STATE_W(4)) dut_nh (
        .clk(clk), .rst(rst_nh), .opcode(op_nh), .mem_ready(1'b0),
        .alu_op(alu_op_nh), .reg_dst(reg_dst_nh),
        .mem_2_reg(mem_2_reg_nh), .reg_write(reg_write_nh),
        .mem_read(mem_read_nh), .mem_write(mem_write_nh),
        .ir_write(ir_write_nh), .pc_write(pc_write_nh),
        .pc_write_cond(pc_write_cond_nh), .i_or_d(i_or_d_nh),
        .alu_src_a(alu_src_a_nh), .alu_src_b(alu_src_b_nh),
        .pc_source(pc_source_nh), .illegal_op(illegal_op_nh),
        .state(state_nh)
    );

    assign vec = {alu_op, reg_dst, mem_2_reg, reg_write, mem_read,
                  mem_write, ir_write, pc_write, pc_write_cond,
                  i_or_d, alu_src_a, alu_src_b, pc_source};
    assign vec_nh = {alu_op_nh, reg_dst_nh, mem_2_reg_nh,
                     reg_write_nh, mem_read_nh, mem_write_nh,
                     ir_write_nh, pc_write_nh, pc_write_cond_nh,
                     i_or_d_nh, alu_src_a_nh, alu_src_b_nh,
                     pc_source_nh};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        opcode    = 6'h23;
        mem_ready = 1'b1;
        rst       = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            vectors++;
            if (vec !== V_RST) begin
                errors++;
                $display("FAIL reset_hold cyc%0d: vec=%b want %b",
                         i, vec, V_RST);
            end
            tick();
        end
        rst = 1'b0;
        @(negedge clk);
        vectors++;
        if (state !== 4'd0 || vec !== V_FETCH || illegal_op !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: st=%0d vec=%b ill=%b want 0 %b 0",
                     state, vec, illegal_op, V_FETCH);
        end
        tick();
    endtask

    task automatic test_lw();
        logic [3:0]  es [6] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd0};
        logic [15:0] ev [6] = '{V_FETCH, V_DEC, V_MADDR, V_MEMRD,
                                V_MEMWB, V_FETCH};
        do_reset();
        opcode    = 6'h23;
        mem_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            vectors++;
            if (state !== es[i] || vec !== ev[i]) begin
                errors++;
                $display("FAIL lw cyc%0d: st=%0d vec=%b want st=%0d vec=%b",
                         i, state, vec, es[i], ev[i]);
            end
            tick();
        end
    endtask

    task automatic test_stalls();
        logic        rd [9] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1,
                                1'b0, 1'b1, 1'b1, 1'b1};
        logic [3:0]  es [9] = '{4'd0, 4'd0, 4'd0, 4'd1, 4'd2,
                                4'd3, 4'd3, 4'd4, 4'd0};
        logic [15:0] ev [9] = '{V_FETCH_S, V_FETCH_S, V_FETCH, V_DEC,
                                V_MADDR, V_MEMRD, V_MEMRD, V_MEMWB,
                                V_FETCH};
        do_reset();
        opcode = 6'h23;
        for (int i = 0; i < 9; i++) begin
            mem_ready = rd[i];
            @(negedge clk);
            vectors++;
            if (state !== es[i] || vec !== ev[i]) begin
                errors++;
                $display("FAIL lw_stall cyc%0d: st=%0d vec=%b want st=%0d vec=%b",
                         i, state, vec, es[i], ev[i]);
            end
            tick();
        end
    endtask

    task automatic test_sw_stall();
        logic        rd [8] = '{1'b1, 1'b1, 1'b1, 1'b0,
                                1'b0, 1'b0, 1'b1, 1'b1};
        logic [3:0]  es [8] = '{4'd0, 4'd1, 4'd2, 4'd5,
                                4'd5, 4'd5, 4'd5, 4'd0};
        logic [15:0] ev [8] = '{V_FETCH, V_DEC, V_MADDR, V_MEMWR,
                                V_MEMWR, V_MEMWR, V_MEMWR, V_FETCH};
        do_reset();
        opcode = 6'h2B;
        for (int i = 0; i < 8; i++) begin
            mem_ready = rd[i];
            @(negedge clk);
            vectors++;
            if (state !== es[i] || vec !== ev[i]) begin
                errors++;
                $display("FAIL sw_stall cyc%0d: st=%0d vec=%b want st=%0d vec=%b",
                         i, state, vec, es[i], ev[i]);
            end
            tick();
        end
    endtask

    task automatic test_back_to_back();
        logic [5:0]  op [15] = '{6'h3F, 6'h00, 6'h3F, 6'h3F,
                                 6'h08, 6'h08, 6'h08, 6'h08,
                                 6'h04, 6'h04, 6'h04,
                                 6'h02, 6'h02, 6'h02, 6'h00};
        logic [3:0]  es [15] = '{4'd0, 4'd1, 4'd6, 4'd7,
                                 4'd0, 4'd1, 4'd10, 4'd11,
                                 4'd0, 4'd1, 4'd8,
                                 4'd0, 4'd1, 4'd9, 4'd0};
        logic [15:0] ev [15] = '{V_FETCH, V_DEC, V_REXEC, V_RWB,
                                 V_FETCH, V_DEC, V_MADDR, V_AWB,
                                 V_FETCH, V_DEC, V_BEQ,
                                 V_FETCH, V_DEC, V_JMP, V_FETCH};
        do_reset();
        mem_ready = 1'b1;
        for (int i = 0; i < 15; i++) begin
            opcode = op[i];
            @(negedge clk);
            vectors++;
            if (state !== es[i] || vec !== ev[i]) begin
                errors++;
                $display("FAIL b2b cyc%0d: st=%0d vec=%b want st=%0d vec=%b",
                         i, state, vec, es[i], ev[i]);
            end
            tick();
        end
    endtask

    task automatic test_trap();
        logic [3:0]  es;
        logic [15:0] ev;
        logic        ei;
        do_reset();
        opcode    = 6'h3F;
        mem_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            es = (i == 0) ? 4'd0 : (i == 1) ? 4'd1 : 4'd12;
            ev = (i == 0) ? V_FETCH : (i == 1) ? V_DEC : V_TRAP;
            ei = (i >= 2);
            @(negedge clk);
            vectors++;
            if (state !== es || vec !== ev || illegal_op !== ei) begin
                errors++;
                $display("FAIL trap cyc%0d: st=%0d vec=%b ill=%b want %0d %b %b",
                         i, state, vec, illegal_op, es, ev, ei);
            end
            tick();
        end
        rst = 1'b1;
        @(negedge clk);
        vectors++;
        if (vec !== V_RST) begin
            errors++;
            $display("FAIL trap_rst: vec=%b want %b", vec, V_RST);
        end
        tick();
        rst = 1'b0;
        @(negedge clk);
        vectors++;
        if (state !== 4'd0 || vec !== V_FETCH || illegal_op !== 1'b0) begin
            errors++;
            $display("FAIL trap_clear: st=%0d vec=%b ill=%b want 0 %b 0",
                     state, vec, illegal_op, V_FETCH);
        end
        tick();
    endtask

    task automatic test_reset_abort();
        do_reset();
        opcode    = 6'h23;
        mem_ready = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        rst = 1'b1;
        @(negedge clk);
        vectors++;
        if (vec !== V_RST) begin
            errors++;
            $display("FAIL abort_memwb: vec=%b want %b", vec, V_RST);
        end
        tick();
        rst = 1'b0;
        @(negedge clk);
        vectors++;
        if (state !== 4'd0 || vec !== V_FETCH) begin
            errors++;
            $display("FAIL abort_memwb_next: st=%0d vec=%b want 0 %b",
                     state, vec, V_FETCH);
        end
        do_reset();
        opcode = 6'h2B;
        for (int i = 0; i < 3; i++) tick();
        mem_ready = 1'b0;
        rst       = 1'b1;
        @(negedge clk);
        vectors++;
        if (vec !== V_RST) begin
            errors++;
            $display("FAIL abort_memwr: vec=%b want %b", vec, V_RST);
        end
        tick();
        rst = 1'b0;
        @(negedge clk);
        vectors++;
        if (state !== 4'd0 || vec !== V_FETCH_S) begin
            errors++;
            $display("FAIL abort_memwr_next: st=%0d vec=%b want 0 %b",
                     state, vec, V_FETCH_S);
        end
        tick();
        mem_ready = 1'b1;
    endtask

    task automatic test_no_handshake();
        logic [3:0]  es [6] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd0};
        logic [15:0] ev [6] = '{V_FETCH, V_DEC, V_MADDR, V_MEMRD,
                                V_MEMWB, V_FETCH};
        op_nh  = 6'h23;
        rst_nh = 1'b1;
        tick();
        rst_nh = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            vectors++;
            if (state_nh !== es[i] || vec_nh !== ev[i]) begin
                errors++;
                $display("FAIL nohs cyc%0d: st=%0d vec=%b want st=%0d vec=%b",
                         i, state_nh, vec_nh, es[i], ev[i]);
            end
            tick();
        end
    endtask

    initial begin
        vectors   = 0;
        errors    = 0;
        rst       = 1'b1;
        opcode    = 6'h23;
        mem_ready = 1'b1;
        rst_nh    = 1'b1;
        op_nh     = 6'h23;
        test_reset();
        test_lw();
        test_stalls();
        test_sw_stall();
        test_back_to_back();
        test_trap();
        test_reset_abort();
        test_no_handshake();
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, errors);
        $finish;
    end

endmodule
